// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with a 2-entry skid buffer, clock-enable and flush.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_skid_stage #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int                CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    // up_ready is a function of registered state and clk_en only, never of dn_ready.
    assign up_ready  = clk_en & (state_q != TWO);
    assign dn_valid  = (state_q != EMPTY);
    assign dn_data   = main_q;
    assign occupancy = state_q;

    assign push = up_valid & up_ready;
    assign pop  = dn_valid & dn_ready & clk_en;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = up_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d  = up_data;
                    end else if (push) begin
                        state_d = TWO;
                        skid_d  = up_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data entries are reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Both counters saturate at all-ones.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (clk_en && dn_valid && !dn_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
        if (flush && (state_q != EMPTY) && (flush_q != {CNT_W{1'b1}}))
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule
